addsub4_checker: RTL and testbench

ADDSUB4_CHECKER -- requirements
Module: addsub4_checker

---
 rtl/addsub4_pkg.sv | 34 +++
 rtl/addsub4_ref.sv | 41 ++++
 rtl/addsub4_checker.sv | 189 ++++++++++++++++++
 tb/tb_addsub4_checker.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub4_pkg.sv
// ----------------------------------------------------------------------------
// addsub4_pkg
//
// Shared definitions for the 4-bit add/subtract exhaustive checker.
//   state_t     : FSM state encoding (IDLE, DRIVE, SETTLE, CHECK, DONE)
//   NUM_VECTORS : number of {op,a,b} vectors in one sweep (512)
//   IDX_W       : width of the vector index / fail_vec (9)
//   ERR_W       : width of the saturating mismatch counter (8)
//   sat_inc()   : saturating increment for the mismatch counter
// ----------------------------------------------------------------------------
package addsub4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int NUM_VECTORS = 512;
    localparam int IDX_W       = 9;
    localparam int ERR_W       = 8;

    // Index of the final vector; the sweep stops here instead of wrapping.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    // Counter sticks at ERR_MAX once reached.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/addsub4_ref.sv
// ----------------------------------------------------------------------------
// addsub4_ref
//
// Purely combinational reference for a 4-bit two's-complement adder/subtractor.
//
// Ports:
//   op       in   0 = a+b, 1 = a-b
//   a, b     in   4-bit two's-complement operands
//   exp_sum  out  5-bit signed result of sign-extended a +/- sign-extended b
//   exp_cout out  carry out of the 4-bit unsigned datapath
//                 (op=0: {0,a}+{0,b}; op=1: {0,a}+{0,~b}+1)
// ----------------------------------------------------------------------------
module addsub4_ref
    import addsub4_pkg::*;
(
    input  logic       op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [4:0] exp_sum,
    output logic       exp_cout
);

    logic [4:0] a_ext;
    logic [4:0] b_ext;
    logic [4:0] uns_b;
    logic [4:0] uns_sum;

    always_comb begin
        // 5 bits are enough to hold every 4-bit sum/difference without overflow.
        a_ext   = {a[3], a};
        b_ext   = {b[3], b};
        exp_sum = op ? (a_ext - b_ext) : (a_ext + b_ext);

        // Carry is defined on the unsigned datapath a real adder/subtractor
        // uses: subtraction is a + ~b with carry-in 1.
        uns_b    = op ? {1'b0, ~b} : {1'b0, b};
        uns_sum  = {1'b0, a} + uns_b + {4'd0, op};
        exp_cout = uns_sum[4];
    end

endmodule

// File: rtl/addsub4_checker.sv
// ----------------------------------------------------------------------------
// addsub4_checker
//
// Exhaustive sweep checker for an external 4-bit adder/subtractor (the DUT).
// On start it steps through all 512 {op,a,b} vectors, holds each for
// SETTLE+2 cycles, compares the DUT result against addsub4_ref and reports a
// saturating mismatch count plus the index of the first failing vector.
//
// Parameters:
//   SETTLE     wait cycles between driving a vector and sampling it (0..15)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begins a sweep when sampled high in IDLE or DONE
//   op         out  to DUT: 0 = add, 1 = subtract
//   c_in       out  to DUT: carry-in, tied to 0
//   a, b       out  to DUT: 4-bit two's-complement operands
//   sum        in   from DUT: 5-bit signed result
//   c_out      in   from DUT: carry-out
//   busy       out  sweep in progress
//   done       out  sweep finished, held until next start
//   pass       out  done with zero mismatches
//   err_count  out  mismatch count, saturating at 255
//   fail_vec   out  {op,a,b} of the first mismatch
//
// Build option:
//   ADDSUB4_CHK_COUT_EN  when defined, c_out is also compared; otherwise the
//                        port is present but ignored.
// ----------------------------------------------------------------------------
module addsub4_checker
    import addsub4_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             op,
    output logic             c_in,
    output logic [3:0]       a,
    output logic [3:0]       b,
    input  logic [4:0]       sum,
    input  logic             c_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] fail_vec
);

    // Settle counter is loaded with SETTLE-1 and counts down to 0, so the FSM
    // spends exactly SETTLE cycles in ST_SETTLE.
    localparam logic [3:0] SETTLE_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [IDX_W-1:0]   fail_q, fail_d;

    logic [4:0]         exp_sum;
    logic               exp_cout;
    logic               mismatch;

    // The operands come straight off the index register, so the DUT sees a
    // new vector from the first cycle of DRIVE and keeps it through IDLE/DONE.
    assign {op, a, b} = idx_q;
    assign c_in       = 1'b0;

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

    addsub4_ref u_ref (
        .op       (op),
        .a        (a),
        .b        (b),
        .exp_sum  (exp_sum),
        .exp_cout (exp_cout)
    );

`ifdef ADDSUB4_CHK_COUT_EN
    assign mismatch = (sum != exp_sum) || (c_out != exp_cout);
`else
    assign mismatch = (sum != exp_sum);

    // c_out stays on the port for drop-in compatibility but is not compared.
    logic unused_cout;
    assign unused_cout = c_out ^ exp_cout;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    idx_d   = '0;
                    err_d   = '0;
                    fail_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end

            ST_DRIVE: begin
                if (SETTLE == 0) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_CHECK: begin
                if (mismatch) begin
                    err_d = sat_inc(err_q);
                    // Only the very first failure is remembered.
                    if (err_q == '0) begin
                        fail_d = idx_q;
                    end
                end

                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = ST_DRIVE;
                    idx_d   = idx_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

endmodule

// File: tb/tb_addsub4_checker.sv
// ----------------------------------------------------------------------------
// tb_addsub4_checker
//
// Drives addsub4_checker against a behavioural adder/subtractor whose faults
// (stuck sum bit, zero sum, stuck carry, random corrupted vectors) are chosen
// per sweep. Expected sweep results are derived from integer arithmetic and
// queued at start; a monitor pops and compares whenever done rises.
// ----------------------------------------------------------------------------
module tb_addsub4_checker;
    import addsub4_pkg::*;

    localparam int SETTLE_P     = 1;
    localparam int SWEEP_CYCLES = NUM_VECTORS * (SETTLE_P + 2);

`ifdef ADDSUB4_CHK_COUT_EN
    localparam bit COUT_EN = 1'b1;
`else
    localparam bit COUT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       op, c_in;
    logic [3:0] a, b;
    logic [4:0] sum;
    logic       c_out;
    logic       busy, done, pass;
    logic [7:0] err_count;
    logic [8:0] fail_vec;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int           fault_mode = 0;   // 0 none, 1 sum[0]=0, 2 sum=0, 3 c_out=1
    bit [511:0]   bad_mask   = '0;  // vectors whose sum LSB is flipped

    typedef struct {
        int err;
        int fail;
        bit pass;
        int start_cyc;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addsub4_checker #(.SETTLE(SETTLE_P)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .c_in      (c_in),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec)
    );

    // Behavioural DUT: sign-extended ripple add with optional faults.
    function automatic logic [5:0] dut_model(input logic [8:0] v, input int mode, input bit bad);
        logic [3:0] bb;
        logic [4:0] s;
        logic [4:0] t;
        logic       co;
        bb = v[8] ? ~v[3:0] : v[3:0];
        s  = {v[7], v[7:4]} + {bb[3], bb} + {4'd0, v[8]};
        t  = {1'b0, v[7:4]} + {1'b0, bb} + {4'd0, v[8]};
        co = t[4];
        case (mode)
            1: s[0] = 1'b0;
            2: s = 5'd0;
            3: co = 1'b1;
            default: ;
        endcase
        if (bad) s = s ^ 5'd1;
        return {co, s};
    endfunction

    always_comb begin
        {c_out, sum} = dut_model({op, a, b}, fault_mode, bad_mask[{op, a, b}]);
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: count how many vectors the current DUT model gets wrong,
    // judged by plain integer arithmetic on the operands.
    task automatic predict(output exp_t e);
        int  cnt;
        int  first;
        cnt   = 0;
        first = 0;
        for (int i = 0; i < NUM_VECTORS; i++) begin
            logic [8:0]        v;
            logic [5:0]        got;
            logic signed [3:0] as, bs;
            logic signed [4:0] gs;
            int sa, sb, ua, ub, want, gsi;
            bit want_c, bad_res;
            v   = 9'(i);
            as  = v[7:4];
            bs  = v[3:0];
            sa  = as;
            sb  = bs;
            ua  = int'(v[7:4]);
            ub  = int'(v[3:0]);
            want   = v[8] ? (sa - sb) : (sa + sb);
            want_c = v[8] ? (ua >= ub) : (ua + ub >= 16);
            got = dut_model(v, fault_mode, bad_mask[i]);
            gs  = got[4:0];
            gsi = gs;
            bad_res = (gsi != want) || (COUT_EN && (got[5] != want_c));
            if (bad_res) begin
                if (cnt == 0) first = i;
                cnt++;
            end
        end
        e.err       = (cnt > 255) ? 255 : cnt;
        e.fail      = first;
        e.pass      = (cnt == 0);
        e.start_cyc = 0;
    endtask

    // Monitor: every rising done is matched against the oldest queued sweep.
    bit done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done && !done_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                $display("sweep done cycle %0d: err_count=%0d fail_vec=%0d pass=%0b (exp %0d/%0d/%0b)",
                         cyc, err_count, fail_vec, pass, e.err, e.fail, e.pass);
                chk("err_count", int'(err_count), e.err);
                chk("fail_vec", int'(fail_vec), e.fail);
                chk("pass", int'(pass), int'(e.pass));
                chk("done_latency", cyc - e.start_cyc, SWEEP_CYCLES);
                chk("last_vector", int'({op, a, b}), NUM_VECTORS - 1);
                chk("busy_at_done", int'(busy), 0);
                chk("c_in", int'(c_in), 0);
            end
        end
        done_prev = done;
    end

    task automatic pulse_start(output int st);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        st = cyc;
    endtask

    task automatic run_sweep(input int mode, input int repulse_at, input int reset_at);
        exp_t e;
        int   st;
        int   n;
        fault_mode = mode;
        predict(e);
        repeat ($urandom_range(1, 6)) @(posedge clk);
        pulse_start(st);
        if (reset_at > 0) begin
            repeat (reset_at - 1) @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("reset_outputs_zero",
                int'({op, a, b, c_in, busy, done, pass, err_count, fail_vec}), 0);
            @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            chk("idle_after_reset", int'({busy, done, err_count}), 0);
            return;
        end
        e.start_cyc = st;
        exp_q.push_back(e);
        repeat (50) @(posedge clk);
        #1 chk("mid_sweep_status", int'({busy, done, pass}), 3'b100);
        if (repulse_at > 50) begin
            repeat (repulse_at - 51) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        n = 0;
        while (exp_q.size() != 0 && n < SWEEP_CYCLES + 100) begin
            @(posedge clk);
            n++;
        end
        chk("done_timeout", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #23;
        chk("reset_outputs_zero",
            int'({op, a, b, c_in, busy, done, pass, err_count, fail_vec}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        bad_mask = '0;
        run_sweep(0, 0, 0);      // clean sweep
        run_sweep(1, 0, 0);      // sum[0] stuck at 0
        run_sweep(2, 0, 0);      // sum stuck at 0
        run_sweep(3, 0, 0);      // c_out stuck at 1
        run_sweep(0, 100, 0);    // start re-pulsed mid-sweep
        run_sweep(2, 0, 300);    // reset mid-sweep of a failing sweep
        run_sweep(0, 0, 0);      // full clean sweep after reset

        for (int it = 0; it < 2; it++) begin
            bad_mask = '0;
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                bad_mask[$urandom_range(0, NUM_VECTORS - 1)] = 1'b1;
            end
            run_sweep(int'($urandom_range(0, 3)), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
